// File: rtl/dst_reg_pipe.sv
// rtl/dst_reg_pipe.sv - write-back destination selector with stall/flush pipeline and forwarding match
//
// Decodes rt / link / rd into a destination register number plus write-enable.
// It then carries the pair through STAGES pipeline registers (stage 0 = EX,
// stage STAGES-1 = WB). The last stage drives the register-file write port.
// Each source register is also matched against the in-flight stages for the
// forwarding unit.
//
// Optional feature: define DST_PIPE_CHECK_EN to enable the sticky illegal-select
// flag on sel_err. When the macro is undefined, sel_err is tied to 0.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high
//   stall      in   freeze all stages
//   flush      in   insert a bubble into stage 0 (older stages still advance)
//   in_valid   in   decode-stage instruction valid
//   reg_write  in   decode-stage instruction writes a register
//   reg_rt     in   rt field
//   reg_rd     in   rd field
//   sel_reg    in   00 rt, 01 LINK_REG, 10 rd, 11 illegal
//   src_rs     in   decode-stage source rs
//   src_rt     in   decode-stage source rt
//   stage_dst  out  per-stage dst, stage k in bits [k*NBITS +: NBITS]
//   stage_we   out  per-stage write-enable
//   wb_dst     out  last-stage dst
//   wb_we      out  last-stage write-enable
//   fwd_rs     out  0 = no match, k+1 = youngest matching stage k
//   fwd_rt     out  as fwd_rs, for src_rt
//   sel_err    out  sticky illegal-select flag

module dst_reg_pipe #(
    parameter int NBITS    = 5,
    parameter int SELBITS  = 2,
    parameter int STAGES   = 3,
    parameter int LINK_REG = 31,
    localparam int FW      = $clog2(STAGES + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic                      reg_write,
    input  logic [NBITS-1:0]          reg_rt,
    input  logic [NBITS-1:0]          reg_rd,
    input  logic [SELBITS-1:0]        sel_reg,
    input  logic [NBITS-1:0]          src_rs,
    input  logic [NBITS-1:0]          src_rt,
    output logic [STAGES*NBITS-1:0]   stage_dst,
    output logic [STAGES-1:0]         stage_we,
    output logic [NBITS-1:0]          wb_dst,
    output logic                      wb_we,
    output logic [FW-1:0]             fwd_rs,
    output logic [FW-1:0]             fwd_rt,
    output logic                      sel_err
);

    logic [NBITS-1:0] dst_d;
    logic             we_d;
    logic             sel_legal;

    logic [NBITS-1:0] dst_q [STAGES];
    logic [STAGES-1:0] we_q;

    // Destination decode. An illegal select decodes to register 0 with no
    // write. Register 0 is hard-wired, so it is never marked as written.
    always_comb begin
        dst_d     = '0;
        sel_legal = 1'b1;
        case (sel_reg)
            SELBITS'(0): dst_d = reg_rt;
            SELBITS'(1): dst_d = NBITS'(LINK_REG);
            SELBITS'(2): dst_d = reg_rd;
            default: begin
                dst_d     = '0;
                sel_legal = 1'b0;
            end
        endcase
        we_d = in_valid & reg_write & sel_legal & (dst_d != '0);
    end

    // Pipeline chain. Flush only bubbles stage 0, so older in-flight writes
    // still retire. Flush overrides stall, which means the rest of the chain
    // advances even during a stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                dst_q[k] <= '0;
            end
            we_q <= '0;
        end else if (flush || !stall) begin
            if (flush) begin
                dst_q[0] <= '0;
                we_q[0]  <= 1'b0;
            end else begin
                dst_q[0] <= dst_d;
                we_q[0]  <= we_d;
            end
            for (int k = 1; k < STAGES; k++) begin
                dst_q[k] <= dst_q[k-1];
                we_q[k]  <= we_q[k-1];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < STAGES; g++) begin : g_out
            assign stage_dst[g*NBITS +: NBITS] = dst_q[g];
        end
    endgenerate

    assign stage_we = we_q;
    assign wb_dst   = dst_q[STAGES-1];
    assign wb_we    = we_q[STAGES-1];

    // Forwarding match. The loop scans from oldest to youngest, so the
    // youngest matching stage is written last and wins.
    always_comb begin
        fwd_rs = '0;
        fwd_rt = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (we_q[k] && (dst_q[k] == src_rs)) begin
                fwd_rs = FW'(k + 1);
            end
            if (we_q[k] && (dst_q[k] == src_rt)) begin
                fwd_rt = FW'(k + 1);
            end
        end
        if (src_rs == '0) begin
            fwd_rs = '0;
        end
        if (src_rt == '0) begin
            fwd_rt = '0;
        end
    end

`ifdef DST_PIPE_CHECK_EN
    logic sel_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_err_q <= 1'b0;
        end else if (in_valid && !sel_legal && !stall) begin
            sel_err_q <= 1'b1;
        end
    end

    assign sel_err = sel_err_q;
`else
    assign sel_err = 1'b0;
`endif

endmodule
